apb_rr_master: RTL and testbench

APB master front-end that shares one APB bus among `NREQ` internal requesters. Each requester uses a simple valid/ready command channel. The block arbitrates round-robin, sequences the APB SETUP and ACCESS phases, and waits on `PREADY`, bounded by a timeout. It returns read data and error status to the winning requester. It sits between bus-initiating agents (DMA, CSR bridge, test sequencer) and the APB slaves on the UART subsystem bus.

---
 rtl/apb_rr_master_if.sv | 33 +++
 rtl/apb_rr_master.sv | 139 +++++++++++++
 tb/tb_apb_rr_master.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_rr_master_if.sv
// Requester command/response channels and the shared APB bus of apb_rr_master.
interface apb_rr_master_if #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   PSELx;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [ADDR_W-1:0]      PADDR;
    logic [DATA_W-1:0]      PWDATA;
    logic [DATA_W-1:0]      PRDATA;
    logic                   PREADY;
    logic                   PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_rr_master.sv
// APB master shared round-robin among NREQ requesters; SETUP/ACCESS sequencing
// with PREADY wait states bounded by an optional timeout.
module apb_rr_master #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic             PCLK,
    input logic             PRESETn,
    apb_rr_master_if.master bus
);
    localparam int unsigned IDX_W  = $clog2(NREQ);
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_last;
    logic [IDX_W-1:0]  r_owner;
    logic [WAIT_W-1:0] r_wait;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_gnt_any;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic [IDX_W-1:0]  w_cand;
    logic [NREQ-1:0]   w_ready;
    logic              w_gnt_write;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_wdata;

    // Search starts one past the last grant, so the previous winner is visited last.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_cand = IDX_W'((32'(r_last) + k) % NREQ);
            if (!w_gnt_any && bus.req_valid[w_cand]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == S_IDLE && w_gnt_any) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_gnt_write = 1'b0;
        w_gnt_addr  = '0;
        w_gnt_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == w_gnt_idx) begin
                w_gnt_write = bus.req_write[i];
                w_gnt_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_gnt_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= S_IDLE;
            r_last      <= IDX_W'(NREQ - 1);
            r_owner     <= '0;
            r_wait      <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_last   <= w_gnt_idx;
                        r_owner  <= w_gnt_idx;
                        r_pwrite <= w_gnt_write;
                        r_paddr  <= w_gnt_addr;
                        r_pwdata <= w_gnt_wdata;
                        r_psel   <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (bus.PREADY) begin
                        r_psel               <= 1'b0;
                        r_penable            <= 1'b0;
                        r_state              <= S_IDLE;
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_rsp_err            <= bus.PSLVERR;
                        r_rsp_rdata          <= r_pwrite ? '0 : bus.PRDATA;
                    end else if (TIMEOUT != 0 && r_wait == WAIT_W'(TIMEOUT - 1)) begin
                        r_psel               <= 1'b0;
                        r_penable            <= 1'b0;
                        r_state              <= S_IDLE;
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_rsp_err            <= 1'b1;
                        r_rsp_rdata          <= '0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.PSELx     = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: transaction table plus reset/contention sequences.
module tb_apb_rr_master;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic clk;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    apb_rr_master_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_rr_master #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK   (clk),
        .PRESETn(rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          nwait;
        logic        slverr;
        logic        noise;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } txn_t;

    txn_t tbl [7];

    function automatic logic [1:0] oh(input int id);
        return 2'b01 << id;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        if (id == 0) begin
            bus.req_write[0]    = wr;
            bus.req_addr[31:0]  = addr;
            bus.req_wdata[31:0] = wdata;
        end else begin
            bus.req_write[1]     = wr;
            bus.req_addr[63:32]  = addr;
            bus.req_wdata[63:32] = wdata;
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, 128'({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.PSELx,
                        bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}), 128'(0));
    endtask

    // Issues one transaction from an idle bus, playing the slave side cycle by cycle.
    task automatic run_txn(input int r, input txn_t t);
        int   cyc;
        logic seen;
        logic hold_ok;
        logic rdy;
        cyc     = 0;
        seen    = 1'b0;
        hold_ok = 1'b1;
        set_req(t.id, t.wr, t.addr, t.wdata);
        bus.req_valid = oh(t.id);
        #1;
        chk($sformatf("row%0d_ready", r), 128'(bus.req_ready), 128'(oh(t.id)));
        @(posedge clk); #1;
        cyc = 1;
        bus.req_valid = '0;
        chk($sformatf("row%0d_setup", r),
            128'({bus.PSELx, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}),
            128'({1'b1, 1'b0, t.wr, t.addr, t.wdata}));
        while (!seen && cyc < 60) begin
            if (cyc >= 2) begin
                if (!(bus.PSELx && bus.PENABLE) || bus.PADDR !== t.addr ||
                    bus.PWRITE !== t.wr || bus.PWDATA !== t.wdata) hold_ok = 1'b0;
                rdy         = (cyc - 2 == t.nwait);
                bus.PREADY  = rdy;
                bus.PSLVERR = rdy ? t.slverr : t.noise;
                bus.PRDATA  = rdy ? t.prdata : 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            cyc++;
            if (bus.rsp_valid != '0) seen = 1'b1;
        end
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        chk($sformatf("row%0d_cycle", r), 128'(cyc), 128'(t.exp_cyc));
        chk($sformatf("row%0d_rsp_valid", r), 128'(bus.rsp_valid), 128'(oh(t.id)));
        chk($sformatf("row%0d_err", r), 128'(bus.rsp_err), 128'(t.exp_err));
        chk($sformatf("row%0d_rdata", r), 128'(bus.rsp_rdata), 128'(t.exp_rdata));
        chk($sformatf("row%0d_bus_idle", r), 128'({bus.PSELx, bus.PENABLE}), 128'(0));
        chk($sformatf("row%0d_access_hold", r), 128'(hold_ok), 128'(1));
    endtask

    initial begin
        int   cyc;
        int   n;
        logic quiet;

        // id, wr, addr, wdata, prdata, nwait, slverr, noise, exp_cyc, exp_err, exp_rdata
        tbl[0] = '{0, 1'b1, 32'h0000_0010, 32'hA5A5_0001, 32'h0000_0055, 0,    1'b0, 1'b0, 3,  1'b0, 32'h0};
        tbl[1] = '{1, 1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 3,    1'b0, 1'b0, 6,  1'b0, 32'h1234_5678};
        tbl[2] = '{0, 1'b1, 32'h0000_0020, 32'h0000_0001, 32'hFFFF_FFFF, 1,    1'b1, 1'b0, 4,  1'b1, 32'h0};
        tbl[3] = '{1, 1'b0, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 0,    1'b0, 1'b0, 3,  1'b0, 32'hCAFE_F00D};
        tbl[4] = '{1, 1'b0, 32'h0000_000C, 32'h0,         32'h0BAD_C0DE, 2,    1'b0, 1'b1, 5,  1'b0, 32'h0BAD_C0DE};
        tbl[5] = '{0, 1'b0, 32'h0000_0030, 32'h0,         32'h1111_2222, 1000, 1'b0, 1'b0, 18, 1'b1, 32'h0};
        tbl[6] = '{1, 1'b0, 32'h0000_0040, 32'h0,         32'h0000_0077, 0,    1'b1, 1'b0, 3,  1'b1, 32'h0000_0077};

        rstn          = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        #12;
        chk_outputs_zero("reset_outputs");
        @(posedge clk); #2;
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < 7; r++) begin
            run_txn(r, tbl[r]);
        end

        // Address/control and last response hold while idle.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("idle_hold", 128'({bus.PADDR, bus.PWRITE, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}),
            128'({32'h0000_0040, 1'b0, 2'b00, 32'h0000_0077, 1'b1}));

        // Reset in the middle of ACCESS wait states of a req0 transfer.
        set_req(0, 1'b1, 32'h0000_0050, 32'h0000_0099);
        bus.req_valid = 2'b01;
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rstn = 1'b0;
        #1;
        chk_outputs_zero("midreset_outputs");
        quiet = 1'b1;
        @(posedge clk); #1;
        if (bus.rsp_valid != '0 || bus.PSELx) quiet = 1'b0;
        @(posedge clk); #1;
        if (bus.rsp_valid != '0 || bus.PSELx) quiet = 1'b0;
        chk("midreset_held", 128'(quiet), 128'(1));
        rstn = 1'b1;
        quiet = 1'b1;
        @(posedge clk); #1;
        if (bus.rsp_valid != '0) quiet = 1'b0;
        @(posedge clk); #1;
        if (bus.rsp_valid != '0) quiet = 1'b0;
        chk("post_reset_no_rsp", 128'(quiet), 128'(1));

        // Contention: both requesters hold valid, zero-wait slave.
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        set_req(1, 1'b0, 32'h0000_0104, 32'h0);
        bus.PREADY    = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        cyc = 0;
        n   = 0;
        while (n < 4 && cyc < 30) begin
            if (bus.req_ready != '0) begin
                chk($sformatf("cont%0d_grant", n), 128'(bus.req_ready), 128'(oh(n % 2)));
                chk($sformatf("cont%0d_idle", n), 128'(bus.PSELx), 128'(0));
                chk($sformatf("cont%0d_cycle", n), 128'(cyc), 128'(3 * n));
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.req_valid = '0;
        chk("cont_grants", 128'(n), 128'(4));
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.PREADY = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
